ic_lshr_ult_search_ctrl: RTL and testbench



---
 rtl/ic_lshr_ult_search_ctrl.sv | 139 +++++++++++++
 tb/tb_ic_lshr_ult_search_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ic_lshr_ult_search_ctrl.sv
// Sequential witness search for (s >> x) <u t: scans x = 0..WIDTH, one candidate per cycle.
// Optional IC_LSHR_ULT_CHECK_EN adds rsp_ic_mismatch against the closed form (t != 0).
module ic_lshr_ult_search_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_s,
    input  logic [WIDTH-1:0] req_t,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_found,
    output logic [WIDTH-1:0] rsp_x,
    output logic [WIDTH:0]   rsp_cycles,
`ifdef IC_LSHR_ULT_CHECK_EN
    output logic             rsp_ic_mismatch,
`endif
    output logic [CNT_W-1:0] sat_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [WIDTH:0]   CAND_LAST = (WIDTH+1)'(WIDTH);
    localparam logic [WIDTH:0]   CAND_ONE  = (WIDTH+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           r_state;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH:0]   r_cand;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic             r_rsp_found;
    logic [WIDTH-1:0] r_rsp_x;
    logic [WIDTH:0]   r_rsp_cycles;
    logic [CNT_W-1:0] r_sat_count;

    logic [WIDTH-1:0] w_shifted;
    logic             w_hit;

    // Shift amounts of WIDTH or more shift everything out and give 0.
    assign w_shifted = r_s >> r_cand;
    assign w_hit     = (w_shifted < r_t);

`ifdef IC_LSHR_ULT_CHECK_EN
    logic r_ic_mismatch;
    logic w_ic_closed;

    assign w_ic_closed     = (r_t != '0);
    assign rsp_ic_mismatch = r_ic_mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ic_mismatch <= 1'b0;
        end else if (r_state == SEARCH && (w_hit || r_cand == CAND_LAST)) begin
            r_ic_mismatch <= (w_hit != w_ic_closed);
        end
    end

    a_ic_match: assert property (@(posedge clk) disable iff (rst)
        !(r_rsp_valid && r_ic_mismatch))
        else $error("search result disagrees with invertibility condition t != 0");
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_s          <= '0;
            r_t          <= '0;
            r_cand       <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_found  <= 1'b0;
            r_rsp_x      <= '0;
            r_rsp_cycles <= '0;
            r_sat_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_s         <= req_s;
                        r_t         <= req_t;
                        r_cand      <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (w_hit) begin
                        r_rsp_found  <= 1'b1;
                        r_rsp_x      <= r_cand[WIDTH-1:0];
                        r_rsp_cycles <= r_cand + CAND_ONE;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                    end else if (r_cand == CAND_LAST) begin
                        r_rsp_found  <= 1'b0;
                        r_rsp_x      <= '0;
                        r_rsp_cycles <= CAND_LAST + CAND_ONE;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= RESP;
                    end else begin
                        r_cand <= r_cand + CAND_ONE;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                        if (r_rsp_found && r_sat_count != CNT_MAX) begin
                            r_sat_count <= r_sat_count + CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_found  = r_rsp_found;
    assign rsp_x      = r_rsp_x;
    assign rsp_cycles = r_rsp_cycles;
    assign sat_count  = r_sat_count;

endmodule

// File: tb/tb_ic_lshr_ult_search_ctrl.sv
// Scoreboard bench for ic_lshr_ult_search_ctrl (WIDTH=4, CNT_W=3 so saturation is reachable).
module tb_ic_lshr_ult_search_ctrl;

    localparam int W = 4;
    localparam int C = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [W-1:0]   req_s;
    logic [W-1:0]   req_t;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_found;
    logic [W-1:0]   rsp_x;
    logic [W:0]     rsp_cycles;
    logic [C-1:0]   sat_count;
`ifdef IC_LSHR_ULT_CHECK_EN
    logic           rsp_ic_mismatch;
`endif

    ic_lshr_ult_search_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_s      (req_s),
        .req_t      (req_t),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_found  (rsp_found),
        .rsp_x      (rsp_x),
        .rsp_cycles (rsp_cycles),
`ifdef IC_LSHR_ULT_CHECK_EN
        .rsp_ic_mismatch (rsp_ic_mismatch),
`endif
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         found;
        logic [W-1:0] x;
        logic [W:0]   cycles;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     exp_sat  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: first x in 0..W with (s >> x) < t; shifts of W or more give 0.
    function automatic exp_t model(input logic [W-1:0] s, input logic [W-1:0] t);
        exp_t         e;
        logic [W-1:0] sh;
        e        = '0;
        e.cycles = (W+1)'(W + 1);
        for (int c = 0; c <= W; c++) begin
            sh = (c >= W) ? '0 : (s >> c);
            if (!e.found && sh < t) begin
                e.found  = 1'b1;
                e.x      = W'(c);
                e.cycles = (W+1)'(c + 1);
            end
        end
        return e;
    endfunction

    task automatic run_req(input logic [W-1:0] s, input logic [W-1:0] t, input int stall);
        exp_t e;
        int   n;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_s     = s;
        req_t     = t;
        req_valid = 1'b1;
        sb.push_back(model(s, t));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_s     = ~s;
        req_t     = ~t;
        chk("req_ready_search", req_ready, 0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        chk("latency", n, e.cycles);
        chk("found", rsp_found, e.found);
        chk("x", rsp_x, e.x);
        chk("cycles", rsp_cycles, e.cycles);
        chk("req_ready_resp", req_ready, 0);
`ifdef IC_LSHR_ULT_CHECK_EN
        chk("ic_mismatch", rsp_ic_mismatch, 0);
`endif
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;
            req_s     = W'($urandom);
            req_t     = W'($urandom);
            @(posedge clk);
            #1;
            chk("stall_valid", rsp_valid, 1);
            chk("stall_found", rsp_found, e.found);
            chk("stall_x", rsp_x, e.x);
            chk("stall_cycles", rsp_cycles, e.cycles);
            chk("stall_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        if (e.found && exp_sat != (1 << C) - 1) exp_sat++;
        chk("post_hs_valid", rsp_valid, 0);
        chk("post_hs_req_ready", req_ready, 1);
        chk("sat_count", sat_count, exp_sat);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_s     = '0;
        req_t     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_found", rsp_found, 0);
        chk("rst_x", rsp_x, 0);
        chk("rst_cycles", rsp_cycles, 0);
        chk("rst_sat", sat_count, 0);
        @(negedge clk);
        rst = 1'b0;

        run_req(4'b1100, 4'b0100, 0);
        run_req(4'b0000, 4'b0001, 0);
        run_req(4'b1111, 4'b0000, 0);
        run_req(4'b1000, 4'b0001, 0);
        run_req(4'b1100, 4'b0100, 10);

        // Reset while the search sits at cand=2.
        @(negedge clk);
        req_s     = 4'b1100;
        req_t     = 4'b0100;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_sat = 0;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_sat", sat_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_rsp", rsp_valid, 0);
        run_req(4'b1100, 4'b0100, 0);

        for (int i = 0; i < 30; i++) begin
            run_req(W'($urandom), (i % 5 == 0) ? '0 : W'($urandom), i % 3);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
